// File: rtl/core_memory_arbiter.sv
// core_memory_arbiter: shares one core memory port between instruction fetch
// and the load/store stage. One owner per transaction, round-robin on ties,
// requester flush drops the request, stalled transactions time out.
module core_memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch side
    input  logic        fetch_enable,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_readData,
    output logic        fetch_ack,
    output logic        fetch_error,
    // load/store side
    input  logic        data_enable,
    input  logic        data_writeEnable,
    input  logic [3:0]  data_byteSelect,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writeData,
    output logic [31:0] data_readData,
    output logic        data_ack,
    output logic        data_error,
    // shared memory port
    output logic        mem_enable,
    output logic        mem_writeEnable,
    output logic [3:0]  mem_byteSelect,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData,
    input  logic        mem_ack,
    output logic        grant_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Counter value at which a still-unacknowledged transaction is abandoned.
    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT =
        COUNTER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

    state_t                   state, nextState;
    logic                     lastGrant, nextLastGrant;   // 0 = fetch, 1 = data
    logic [COUNTER_WIDTH-1:0] counter, nextCounter;

    logic ownerData;   // current owner is the load/store side
    logic ownerEnable; // owner's live request
    logic done;        // owner completes with mem_ack this cycle
    logic timedOut;    // owner is aborted by the timeout this cycle
    logic timeoutHit;

    assign timeoutHit = TIMEOUT_ON && (counter == LAST_COUNT);

    // State, round-robin pointer and timeout counter; async reset drops any
    // in-flight request immediately since all port outputs decode from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= 1'b0;
            counter   <= '0;
        end else begin
            state     <= nextState;
            lastGrant <= nextLastGrant;
            counter   <= nextCounter;
        end
    end

    // Grant decision, shared-port steering and completion/abort outputs.
    always_comb begin
        nextState       = state;
        nextLastGrant   = lastGrant;
        nextCounter     = counter;
        ownerData       = 1'b0;
        ownerEnable     = 1'b0;
        done            = 1'b0;
        timedOut        = 1'b0;
        mem_enable      = 1'b0;
        mem_writeEnable = 1'b0;
        mem_byteSelect  = 4'b0000;
        mem_address     = 32'h0;
        mem_writeData   = 32'h0;

        case (state)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (data_enable && (!fetch_enable || !lastGrant)) begin
                    nextState     = DATA;
                    nextLastGrant = 1'b1;
                    nextCounter   = '0;
                end else if (fetch_enable) begin
                    nextState     = FETCH;
                    nextLastGrant = 1'b0;
                    nextCounter   = '0;
                end
            end
            FETCH, DATA: begin
                ownerData   = (state == DATA);
                ownerEnable = ownerData ? data_enable : fetch_enable;
                if (!ownerEnable) begin
                    // Requester flushed: withdraw the request, ignore any ack.
                    nextState = IDLE;
                end else begin
                    mem_enable = 1'b1;
                    if (ownerData) begin
                        mem_writeEnable = data_writeEnable;
                        mem_byteSelect  = data_byteSelect;
                        mem_address     = data_address;
                        mem_writeData   = data_writeData;
                    end else begin
                        mem_byteSelect  = 4'b1111;
                        mem_address     = fetch_address;
                    end
                    if (mem_ack) begin
                        // An ack on the last allowed cycle still wins.
                        done      = 1'b1;
                        nextState = IDLE;
                    end else if (timeoutHit) begin
                        timedOut  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextCounter = counter + COUNTER_WIDTH'(1);
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Responses go only to the owner; read data is zero unless acknowledged.
    always_comb begin
        fetch_ack      = done && !ownerData;
        fetch_error    = timedOut && !ownerData;
        data_ack       = done && ownerData;
        data_error     = timedOut && ownerData;
        fetch_readData = fetch_ack ? mem_readData : 32'h0;
        data_readData  = data_ack ? mem_readData : 32'h0;
        grant_data     = (state == DATA);
    end

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed bench for core_memory_arbiter (TIMEOUT_CYCLES=4). Stimulus pushes
// expected responses into a queue; a monitor pops them on every ack/error.
module tb_core_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_enable;
    logic [31:0] fetch_address;
    logic [31:0] fetch_readData;
    logic        fetch_ack, fetch_error;
    logic        data_enable, data_writeEnable;
    logic [3:0]  data_byteSelect;
    logic [31:0] data_address, data_writeData, data_readData;
    logic        data_ack, data_error;
    logic        mem_enable, mem_writeEnable;
    logic [3:0]  mem_byteSelect;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_ack;
    logic        grant_data;

    typedef struct packed {
        logic        side;  // 1 = data
        logic        err;
        logic [31:0] rd;
    } resp_t;

    resp_t expQ[$];
    int checks = 0;
    int errors = 0;

    core_memory_arbiter #(.TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .fetch_enable(fetch_enable), .fetch_address(fetch_address),
        .fetch_readData(fetch_readData), .fetch_ack(fetch_ack), .fetch_error(fetch_error),
        .data_enable(data_enable), .data_writeEnable(data_writeEnable),
        .data_byteSelect(data_byteSelect), .data_address(data_address),
        .data_writeData(data_writeData), .data_readData(data_readData),
        .data_ack(data_ack), .data_error(data_error),
        .mem_enable(mem_enable), .mem_writeEnable(mem_writeEnable),
        .mem_byteSelect(mem_byteSelect), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData),
        .mem_ack(mem_ack), .grant_data(grant_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic side, input logic err, input logic [31:0] rd);
        resp_t r;
        r.side = side; r.err = err; r.rd = rd;
        expQ.push_back(r);
    endtask

    // Monitor: samples 3 time units after each negedge, before the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (fetch_ack || fetch_error || data_ack || data_error) begin
                resp_t r;
                logic  side, err;
                logic [31:0] rd;
                chk("one_response", 32'(fetch_ack + fetch_error + data_ack + data_error), 32'd1);
                side = data_ack || data_error;
                err  = fetch_error || data_error;
                rd   = side ? data_readData : fetch_readData;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got side=%0d err=%0d rd=0x%08h expected none",
                             side, err, rd);
                end else begin
                    r = expQ.pop_front();
                    chk("resp_side", 32'(side), 32'(r.side));
                    chk("resp_err",  32'(err),  32'(r.err));
                    chk("resp_data", rd, r.rd);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        fetch_enable = 0; fetch_address = 0;
        data_enable = 0; data_writeEnable = 0; data_byteSelect = 0;
        data_address = 0; data_writeData = 0;
        mem_ack = 0; mem_readData = 0;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        #1;
        chk("reset_mem_enable", 32'(mem_enable), 0);
        chk("reset_grant_data", 32'(grant_data), 0);
        chk("reset_acks", 32'({fetch_ack, fetch_error, data_ack, data_error}), 0);
        step();
        rst = 1'b0;

        // Contention from reset: DATA, FETCH, DATA, FETCH, 2 cycles each.
        step();
        fetch_enable = 1; fetch_address = 32'h40;
        data_enable = 1; data_address = 32'h80; data_byteSelect = 4'hF;
        mem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_idle_grant", 32'(grant_data), 0);
            chk("tie_idle_mem_en", 32'(mem_enable), 0);
            step();
            mem_readData = 32'h1000 + 32'(k);
            push((k % 2) == 0, 1'b0, 32'h1000 + 32'(k));
            #1;
            chk("tie_owner", 32'(grant_data), 32'((k % 2) == 0));
            chk("tie_addr", mem_address, ((k % 2) == 0) ? 32'h80 : 32'h40);
            step();
        end
        idleInputs();

        // Single load, acked in the 3rd owner cycle.
        step();
        data_enable = 1; data_address = 32'h100; data_byteSelect = 4'b0011;
        #1 chk("load_idle_grant", 32'(grant_data), 0);
        step();
        #1;
        chk("load_mem_en", 32'(mem_enable), 1);
        chk("load_addr", mem_address, 32'h100);
        chk("load_bs", 32'(mem_byteSelect), 32'h3);
        step();
        step();
        mem_ack = 1; mem_readData = 32'hDEADBEEF;
        push(1'b1, 1'b0, 32'hDEADBEEF);
        #1 chk("load_ack", 32'(data_ack), 1);
        step();
        idleInputs();
        #1;
        chk("load_after_grant", 32'(grant_data), 0);
        chk("load_after_mem_en", 32'(mem_enable), 0);

        // Fetch forcing: write controls masked even with data-side noise.
        step();
        fetch_enable = 1; fetch_address = 32'h2000;
        data_writeEnable = 1; data_writeData = 32'h55; data_byteSelect = 4'h1;
        step();
        #1;
        chk("fetch_addr", mem_address, 32'h2000);
        chk("fetch_we", 32'(mem_writeEnable), 0);
        chk("fetch_bs", 32'(mem_byteSelect), 32'hF);
        chk("fetch_wd", mem_writeData, 0);
        mem_ack = 1; mem_readData = 32'hCAFEF00D;
        push(1'b0, 1'b0, 32'hCAFEF00D);
        step();
        idleInputs();

        // Timeout: store never acked, error in the 4th owner cycle.
        step();
        data_enable = 1; data_writeEnable = 1; data_byteSelect = 4'hF;
        data_address = 32'h300; data_writeData = 32'h12345678;
        step();
        #1;
        chk("store_we", 32'(mem_writeEnable), 1);
        chk("store_wd", mem_writeData, 32'h12345678);
        step();
        #1 chk("store_c2_err", 32'(data_error), 0);
        step();
        #1 chk("store_c3_err", 32'(data_error), 0);
        step();
        push(1'b1, 1'b1, 32'h0);
        #1 chk("store_timeout_err", 32'(data_error), 1);
        step();
        #1 chk("store_after_mem_en", 32'(mem_enable), 0);
        data_enable = 0;

        // Same store, ack arrives in the 4th owner cycle and wins.
        step();
        data_enable = 1;
        step();
        step();
        step();
        step();
        mem_ack = 1; mem_readData = 32'hA5A5A5A5;
        push(1'b1, 1'b0, 32'hA5A5A5A5);
        #1 chk("store_last_err", 32'(data_error), 0);
        step();
        idleInputs();

        // Flush: data drops in its 2nd owner cycle with mem_ack high.
        step();
        data_enable = 1; data_address = 32'h400; data_byteSelect = 4'hF;
        step();
        fetch_enable = 1; fetch_address = 32'h3000;
        step();
        data_enable = 0; mem_ack = 1; mem_readData = 32'hBAD;
        #1;
        chk("flush_mem_en", 32'(mem_enable), 0);
        chk("flush_ack", 32'(data_ack), 0);
        step();
        mem_ack = 0;
        #1;
        chk("flush_idle_grant", 32'(grant_data), 0);
        chk("flush_idle_mem_en", 32'(mem_enable), 0);
        step();
        #1;
        chk("flush_fetch_en", 32'(mem_enable), 1);
        chk("flush_fetch_addr", mem_address, 32'h3000);
        mem_ack = 1; mem_readData = 32'h77;
        push(1'b0, 1'b0, 32'h77);
        step();
        idleInputs();

        // Async reset between edges while data owns the port.
        step();
        data_enable = 1; data_address = 32'h500; data_byteSelect = 4'hF;
        step();
        #1 chk("arst_pre_grant", 32'(grant_data), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_en", 32'(mem_enable), 0);
        chk("arst_grant", 32'(grant_data), 0);
        step();
        rst = 1'b0;
        fetch_enable = 1; fetch_address = 32'h600;
        step();
        #1;
        chk("arst_tie_grant", 32'(grant_data), 1);
        chk("arst_tie_addr", mem_address, 32'h500);
        mem_ack = 1; mem_readData = 32'h5151;
        push(1'b1, 1'b0, 32'h5151);
        step();
        idleInputs();

        step();
        step();
        chk("scoreboard_empty", 32'(expQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
